// File: rtl/cv32e40p_obi_arbiter.sv
// Two-master OBI arbiter: shares one memory port between the instruction and
// data interfaces with round-robin tie-break, request locking while stalled,
// and an in-order ID FIFO that routes responses back to the right master.
module cv32e40p_obi_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Owner encoding: 0 = instruction side, 1 = data side
    logic             r_prio;
    logic             r_lock;
    logic             r_lock_owner;
    logic             r_err;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_id_fifo [MAX_OUTSTANDING];

    logic w_full;
    logic w_empty;
    logic w_sel;
    logic w_grant;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == CNT_MAX);
    assign w_empty = (r_count == '0);
    assign w_head  = r_id_fifo[r_rptr];

    // Owner selection: locked owner first, then sole requester, then round-robin
    always_comb begin
        w_sel = ~r_prio;
        if (r_lock) begin
            w_sel = r_lock_owner;
        end else if (instr_req_i && !data_req_i) begin
            w_sel = 1'b0;
        end else if (data_req_i && !instr_req_i) begin
            w_sel = 1'b1;
        end
    end

    assign mem_req_o   = (instr_req_i | data_req_i) & ~w_full;
    assign w_grant     = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_grant & ~w_sel;
    assign data_gnt_o  = w_grant &  w_sel;

    assign mem_addr_o  = w_sel ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = w_sel & data_we_i;
    assign mem_be_o    = w_sel ? data_be_i    : 4'hF;
    assign mem_wdata_o = w_sel ? data_wdata_i : 32'h0;

    // Responses follow the FIFO head; a response with nothing outstanding is dropped
    assign w_pop          = mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_pop & ~w_head;
    assign data_rvalid_o  = w_pop &  w_head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = r_err;

    // Round-robin pointer follows the most recently granted owner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prio <= 1'b0;
        end else if (w_grant) begin
            r_prio <= w_sel;
        end
    end

    // Hold the owner of a stalled request until it is granted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock       <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (w_grant) begin
            r_lock       <= 1'b0;
        end else if (mem_req_o) begin
            r_lock       <= 1'b1;
            r_lock_owner <= w_sel;
        end
    end

    // Outstanding-transaction counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID FIFO write side
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                r_id_fifo[i] <= 1'b0;
            end
        end else if (w_grant) begin
            r_id_fifo[r_wptr] <= w_sel;
            r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
        end
    end

    // ID FIFO read side
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
        end
    end

    // Sticky flag for an unexpected response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (mem_rvalid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Directed bench for the OBI arbiter: a cycle table walking tie-break, full,
// lock and ordering cases, followed by hand-written reset/error sequences.
module tb_cv32e40p_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_gnt, mem_rvalid, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .err_o(err)
    );

    typedef struct {
        logic        ir, dr;
        logic [31:0] ia, da;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwd;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        e_mreq, e_ig, e_dg;
        logic [31:0] e_ma;
        logic [3:0]  e_mbe;
        logic        e_mwe;
        logic [31:0] e_mwd;
        logic        e_irv, e_drv, e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic [31:0] ia,
                         input logic [31:0] da, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] dwd, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        instr_req = ir; data_req = dr; instr_addr = ia; data_addr = da;
        data_we = dwe; data_be = dbe; data_wdata = dwd;
        mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Tie-break, simultaneous push/pop, full, drain
        vecs[0]  = '{1,1,32'h10,32'h20,0,4'h3,32'h55,1,0,32'h0,    1,0,1,32'h20,4'h3,0,32'h55,0,0,0};
        vecs[1]  = '{1,1,32'h10,32'h20,0,4'h3,32'h55,1,1,32'h11,   1,1,0,32'h10,4'hF,0,32'h0, 0,1,0};
        vecs[2]  = '{1,1,32'h10,32'h20,0,4'h3,32'h55,1,1,32'h22,   1,0,1,32'h20,4'h3,0,32'h55,1,0,0};
        vecs[3]  = '{1,1,32'h10,32'h20,0,4'h3,32'h55,1,0,32'h0,    1,1,0,32'h10,4'hF,0,32'h0, 0,0,0};
        vecs[4]  = '{1,1,32'h10,32'h20,0,4'h3,32'h55,1,1,32'hAAAA, 0,0,0,32'h20,4'h3,0,32'h55,0,1,0};
        vecs[5]  = '{1,0,32'h10,32'h20,0,4'h3,32'h55,1,1,32'hBBBB, 1,1,0,32'h10,4'hF,0,32'h0, 1,0,0};
        vecs[6]  = '{0,0,32'h10,32'h20,0,4'h3,32'h55,0,1,32'h1234, 0,0,0,32'h20,4'h3,0,32'h55,1,0,0};
        // Stall and lock on instruction owner while data arrives
        vecs[7]  = '{1,0,32'h100,32'h20,0,4'h3,32'h55,0,0,32'h0,   1,0,0,32'h100,4'hF,0,32'h0,0,0,0};
        vecs[8]  = '{1,1,32'h100,32'h200,1,4'h5,32'h99,0,0,32'h0,  1,0,0,32'h100,4'hF,0,32'h0,0,0,0};
        vecs[9]  = '{1,1,32'h100,32'h200,1,4'h5,32'h99,0,0,32'h0,  1,0,0,32'h100,4'hF,0,32'h0,0,0,0};
        vecs[10] = '{1,1,32'h100,32'h200,1,4'h5,32'h99,1,0,32'h0,  1,1,0,32'h100,4'hF,0,32'h0,0,0,0};
        vecs[11] = '{0,1,32'h100,32'h200,1,4'h5,32'h99,1,0,32'h0,  1,0,1,32'h200,4'h5,1,32'h99,0,0,0};
        // In-order responses, then a stray response
        vecs[12] = '{0,0,32'h100,32'h200,1,4'h5,32'h99,0,1,32'hAAAA, 0,0,0,32'h100,4'hF,0,32'h0,1,0,0};
        vecs[13] = '{0,0,32'h100,32'h200,1,4'h5,32'h99,0,1,32'hBBBB, 0,0,0,32'h100,4'hF,0,32'h0,0,1,0};
        vecs[14] = '{0,0,32'h100,32'h200,1,4'h5,32'h99,0,0,32'h0,    0,0,0,32'h100,4'hF,0,32'h0,0,0,0};
        vecs[15] = '{0,0,32'h100,32'h200,1,4'h5,32'h99,0,1,32'hCCCC, 0,0,0,32'h100,4'hF,0,32'h0,0,0,0};
        vecs[16] = '{0,0,32'h100,32'h200,1,4'h5,32'h99,0,0,32'h0,    0,0,0,32'h100,4'hF,0,32'h0,0,0,1};

        rst = 1'b1;
        drive(1, 0, 32'h10, 32'h20, 0, 4'h3, 32'h55, 0, 0, 32'h0);
        next_cycle();
        next_cycle();
        check("reset mem_req", 32'(mem_req), 32'd1);
        check("reset err", 32'(err), 32'd0);
        check("reset instr_rvalid", 32'(instr_rvalid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ir, vecs[i].dr, vecs[i].ia, vecs[i].da, vecs[i].dwe,
                  vecs[i].dbe, vecs[i].dwd, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            #3;
            check($sformatf("v%0d mem_req", i),      32'(mem_req),      32'(vecs[i].e_mreq));
            check($sformatf("v%0d instr_gnt", i),    32'(instr_gnt),    32'(vecs[i].e_ig));
            check($sformatf("v%0d data_gnt", i),     32'(data_gnt),     32'(vecs[i].e_dg));
            check($sformatf("v%0d mem_addr", i),     mem_addr,          vecs[i].e_ma);
            check($sformatf("v%0d mem_be", i),       32'(mem_be),       32'(vecs[i].e_mbe));
            check($sformatf("v%0d mem_we", i),       32'(mem_we),       32'(vecs[i].e_mwe));
            check($sformatf("v%0d mem_wdata", i),    mem_wdata,         vecs[i].e_mwd);
            check($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid), 32'(vecs[i].e_irv));
            check($sformatf("v%0d data_rvalid", i),  32'(data_rvalid),  32'(vecs[i].e_drv));
            check($sformatf("v%0d err", i),          32'(err),          32'(vecs[i].e_err));
            check($sformatf("v%0d instr_rdata", i),  instr_rdata,       vecs[i].rd);
            check($sformatf("v%0d data_rdata", i),   data_rdata,        vecs[i].rd);
            next_cycle();
        end

        // Error flag is sticky until reset, and reset clears it asynchronously
        drive(0, 0, 32'h10, 32'h20, 0, 4'h3, 32'h0, 0, 0, 32'h0);
        #2;
        check("err sticky", 32'(err), 32'd1);
        next_cycle();
        drive(1, 0, 32'h10, 32'h20, 0, 4'h3, 32'h0, 0, 0, 32'h0);
        rst = 1'b1;
        #1;
        check("async reset err", 32'(err), 32'd0);
        check("reset mem_req follows req", 32'(mem_req), 32'd1);
        next_cycle();
        rst = 1'b0;

        // One data transaction in flight, then reset discards it
        drive(0, 1, 32'h10, 32'h40, 0, 4'hF, 32'h0, 1, 0, 32'h0);
        #2;
        check("pre-reset data_gnt", 32'(data_gnt), 32'd1);
        check("pre-reset mem_addr", mem_addr, 32'h40);
        next_cycle();
        drive(0, 0, 32'h10, 32'h40, 0, 4'hF, 32'h0, 0, 0, 32'h0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 32'h10, 32'h40, 0, 4'hF, 32'h0, 0, 1, 32'hDDDD);
        #2;
        check("post-reset instr_rvalid", 32'(instr_rvalid), 32'd0);
        check("post-reset data_rvalid", 32'(data_rvalid), 32'd0);
        check("post-reset err same cycle", 32'(err), 32'd0);
        next_cycle();
        drive(0, 0, 32'h10, 32'h40, 0, 4'hF, 32'h0, 0, 0, 32'h0);
        #2;
        check("post-reset err next cycle", 32'(err), 32'd1);
        next_cycle();
        check("post-reset err held", 32'(err), 32'd1);
        check("post-reset mem_req idle", 32'(mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
